// File: rtl/cpu_mem_responder_pkg.sv
// Shared types and constants for the CPU memory responder: FSM encoding,
// I/O register map and the I/O window decode helper.
package cpu_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IO_LED  = 2'd0,
        IO_SW   = 2'd1,
        IO_CNT  = 2'd2,
        IO_STAT = 2'd3
    } io_reg_t;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;

    // A word address hits the 16-byte I/O window when its upper 28 bits match the base.
    function automatic logic in_io_window(input logic [29:0] word, input logic [27:0] base_hi);
        return word[29:2] == base_hi;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// CPU-side memory bus: request strobes and address/data from the CPU,
// read data, completion pulse and busy flag back from the responder.
interface cpu_mem_responder_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_r;
    logic        mem_w;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    modport master (
        output mem_addr, mem_wdata, mem_r, mem_w,
        input  mem_rdata, mem_ready, busy
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_r, mem_w,
        output mem_rdata, mem_ready, busy
    );
endinterface

// File: rtl/cpu_mem_responder_resp_ram.sv
// Single-port synchronous RAM with registered read; the output register only
// moves on a read so it holds the last read word across writes.
module resp_ram #(
    parameter int MEM_WORDS = 1024
) (
    input  logic                                          clk,
    input  logic                                          en,
    input  logic                                          we,
    input  logic [((MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1)-1:0] addr,
    input  logic [31:0]                                   wdata,
    output logic [31:0]                                   rdata
);
    logic [31:0] mem_r [MEM_WORDS];

    // One access per cycle: write, or registered read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= wdata;
            end else begin
                rdata <= mem_r[addr];
            end
        end
    end
endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the multi-cycle CPU bus: RAM, memory-mapped I/O
// (LED, switches, cycle counter, status) and a programmable wait-state FSM.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    cpu_mem_responder_if.slave bus,
    input  logic [15:0]        sw_in,
    output logic [15:0]        led_out,
    output logic               err
);
    localparam int         AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam state_t     ACCEPT_NEXT = (WAIT_CYCLES > 0) ? WAIT : RESP;

    state_t      state_r;
    logic [3:0]  wait_cnt_r;
    logic [29:0] word_r;
    logic [31:0] wdata_r;
    logic        is_write_r;
    logic        txn_err_r;
    logic        busy_r;
    logic        ready_r;
    logic [15:0] led_r;
    logic [15:0] sw_meta_r;
    logic [15:0] sw_sync_r;
    logic [31:0] cnt_r;
    logic [31:0] io_rdata_r;
    logic        from_ram_r;
    logic        err_r;

    logic        accept_s;
    logic [29:0] cap_word_s;
    logic        cap_read_s;
    logic        cap_io_s;
    logic        cap_ram_s;
    io_reg_t     cap_reg_s;
    logic        rd_capture_s;
    logic        commit_s;
    logic        req_bad_s;
    logic        led_load_s;
    logic        cnt_load_s;
    logic        stat_clear_s;
    logic        ram_en_s;
    logic [31:0] io_rd_s;
    logic [31:0] ram_rdata_s;

    function automatic logic in_ram(input logic [29:0] word);
        return {2'b00, word} < 32'(MEM_WORDS);
    endfunction

    // Decode works on the live bus address while idle and on the latched one afterwards,
    // so a zero-wait read can still be captured on its accept edge.
    always_comb begin
        accept_s     = (state_r == IDLE) && (bus.mem_r || bus.mem_w);
        cap_word_s   = (state_r == IDLE) ? bus.mem_addr[31:2] : word_r;
        cap_read_s   = (state_r == IDLE) ? (bus.mem_r && !bus.mem_w) : !is_write_r;
        cap_io_s     = in_io_window(cap_word_s, IO_BASE[31:4]);
        cap_ram_s    = !cap_io_s && in_ram(cap_word_s);
        cap_reg_s    = io_reg_t'(cap_word_s[1:0]);
        rd_capture_s = cap_read_s &&
                       (((state_r == IDLE) && accept_s && (WAIT_CYCLES == 0)) ||
                        ((state_r == WAIT) && (wait_cnt_r == 4'd0)));
        commit_s     = (state_r == RESP) && is_write_r;
        req_bad_s    = (bus.mem_r && bus.mem_w) || (bus.mem_addr[1:0] != 2'b00) ||
                       (!cap_io_s && !cap_ram_s);
        led_load_s   = commit_s && cap_io_s && (cap_reg_s == IO_LED);
        cnt_load_s   = commit_s && cap_io_s && (cap_reg_s == IO_CNT);
        stat_clear_s = commit_s && cap_io_s && (cap_reg_s == IO_STAT) && wdata_r[0];
        ram_en_s     = cap_ram_s && (rd_capture_s || commit_s);
        io_rd_s      = 32'h0000_0000;
        case (cap_reg_s)
            IO_LED:  io_rd_s = {16'h0000, led_r};
            IO_SW:   io_rd_s = {16'h0000, sw_sync_r};
            IO_CNT:  io_rd_s = cnt_r;
            // A STAT read always observes its own transaction in flight.
            IO_STAT: io_rd_s = {30'h0000_0000, 1'b1, err_r};
            default: io_rd_s = 32'h0000_0000;
        endcase
    end

    // Transaction FSM: accept, wait-state countdown, one-cycle response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
            word_r     <= 30'd0;
            wdata_r    <= 32'h0000_0000;
            is_write_r <= 1'b0;
            txn_err_r  <= 1'b0;
            busy_r     <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        word_r     <= bus.mem_addr[31:2];
                        wdata_r    <= bus.mem_wdata;
                        is_write_r <= bus.mem_w;
                        txn_err_r  <= req_bad_s;
                        wait_cnt_r <= WAIT_LOAD;
                        busy_r     <= 1'b1;
                        ready_r    <= (WAIT_CYCLES == 0);
                        state_r    <= ACCEPT_NEXT;
                    end else begin
                        busy_r     <= 1'b0;
                        ready_r    <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == 4'd0) begin
                        ready_r <= 1'b1;
                        state_r <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // I/O registers, counter, sticky error and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r      <= 16'h0000;
            sw_meta_r  <= 16'h0000;
            sw_sync_r  <= 16'h0000;
            cnt_r      <= 32'h0000_0000;
            err_r      <= 1'b0;
            io_rdata_r <= 32'h0000_0000;
            from_ram_r <= 1'b0;
        end else begin
            sw_meta_r <= sw_in;
            sw_sync_r <= sw_meta_r;
            cnt_r     <= cnt_load_s ? wdata_r : cnt_r + 32'd1;
            if (led_load_s) begin
                led_r <= wdata_r[15:0];
            end
            // A fault raised by the clearing transaction itself keeps err set.
            if (state_r == RESP) begin
                err_r <= txn_err_r | (err_r & !stat_clear_s);
            end
            if (rd_capture_s) begin
                from_ram_r <= cap_ram_s;
                io_rdata_r <= cap_io_s ? io_rd_s : 32'h0000_0000;
            end
        end
    end

    resp_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (commit_s),
        .addr  (cap_word_s[AW-1:0]),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    assign bus.mem_rdata = from_ram_r ? ram_rdata_s : io_rdata_r;
    assign bus.mem_ready = ready_r;
    assign bus.busy      = busy_r;
    assign led_out       = led_r;
    assign err           = err_r;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench: transaction-level model for a WAIT_CYCLES=1 responder
// checked every cycle, plus directed literal checks and a zero-wait instance.
module tb_cpu_mem_responder;
    localparam int          W    = 1;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        err;
    logic [15:0] led0;
    logic        err0;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    cpu_mem_responder_if bus ();
    cpu_mem_responder_if bus0 ();

    cpu_mem_responder #(.MEM_WORDS(1024), .WAIT_CYCLES(W), .IO_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .bus(bus), .sw_in(sw_in), .led_out(led_out), .err(err)
    );

    cpu_mem_responder #(.MEM_WORDS(1024), .WAIT_CYCLES(0), .IO_BASE(BASE)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .sw_in(sw_in), .led_out(led0), .err(err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_active = 1'b0;
    int          m_acc    = 0;
    int          edge_no  = 0;
    logic        m_write  = 1'b0;
    logic        m_bad    = 1'b0;
    logic [31:0] m_addr   = 32'h0;
    logic [31:0] m_wdata  = 32'h0;
    logic [31:0] exp_rdata = 32'h0;
    logic [15:0] exp_led  = 16'h0;
    logic        exp_err  = 1'b0;
    logic [31:0] m_cnt    = 32'h0;
    logic [15:0] m_sw1    = 16'h0;
    logic [15:0] m_sw2    = 16'h0;
    logic [31:0] mem_m [int];

    // 0 = RAM, 1 = I/O, 2 = out of range
    function automatic int region(input logic [31:0] a);
        if (a - BASE < 32'd16) return 1;
        if (a < 32'd4096) return 0;
        return 2;
    endfunction

    function automatic logic [31:0] read_value(input logic [31:0] a);
        int r = region(a);
        if (r == 0) return mem_m.exists(int'(a >> 2)) ? mem_m[int'(a >> 2)] : 32'h0;
        if (r == 2) return 32'h0;
        case ((a - BASE) >> 2)
            32'd0:   return {16'h0, exp_led};
            32'd1:   return {16'h0, m_sw2};
            32'd2:   return m_cnt;
            default: return {30'h0, 1'b1, exp_err};
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        logic was;
        logic cnt_load;
        logic clr;
        if (reset) begin
            m_active = 1'b0; exp_rdata = 32'h0; exp_led = 16'h0; exp_err = 1'b0;
            m_cnt = 32'h0; m_sw1 = 16'h0; m_sw2 = 16'h0;
        end else begin
            edge_no++;
            was = m_active; cnt_load = 1'b0; clr = 1'b0;
            if (!was && (bus.mem_r || bus.mem_w)) begin
                m_active = 1'b1; m_acc = edge_no; m_write = bus.mem_w;
                m_addr = bus.mem_addr; m_wdata = bus.mem_wdata;
                m_bad = (bus.mem_r && bus.mem_w) || (bus.mem_addr[1:0] != 2'b00) ||
                        (region(bus.mem_addr) == 2);
            end
            if (m_active && !m_write && edge_no == m_acc + W) exp_rdata = read_value(m_addr);
            if (was && edge_no == m_acc + W + 1) begin
                if (m_write && region(m_addr) == 0) mem_m[int'(m_addr >> 2)] = m_wdata;
                if (m_write && region(m_addr) == 1) begin
                    case ((m_addr - BASE) >> 2)
                        32'd0:   exp_led = m_wdata[15:0];
                        32'd2:   cnt_load = 1'b1;
                        32'd3:   clr = m_wdata[0];
                        default: ;
                    endcase
                end
                exp_err = m_bad | (exp_err & !clr);
                m_active = 1'b0;
            end
            m_cnt = cnt_load ? m_wdata : m_cnt + 32'd1;
            m_sw2 = m_sw1; m_sw1 = sw_in;
        end
    end

    // Every-cycle comparison of the main DUT against the model.
    always @(negedge clk) begin
        chk("busy", {31'h0, bus.busy}, {31'h0, m_active});
        chk("mem_ready", {31'h0, bus.mem_ready}, {31'h0, m_active && (edge_no == m_acc + W)});
        chk("mem_rdata", bus.mem_rdata, exp_rdata);
        chk("led_out", {16'h0, led_out}, {16'h0, exp_led});
        chk("err", {31'h0, err}, {31'h0, exp_err});
    end

    // ---------------- stimulus ----------------
    // Called at negedge+1 of an idle cycle; returns at negedge+1 of the next idle cycle.
    task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic seen = 1'b0;
        bus.mem_r = r; bus.mem_w = w; bus.mem_addr = a; bus.mem_wdata = d;
        @(posedge clk); #1;
        bus.mem_r = 1'b0; bus.mem_w = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_ready) seen = 1'b1;
        end
        chk("ready_timeout", {31'h0, seen}, 32'h1);
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        sw_in = 16'h00F0;
        bus.mem_r = 1'b0;  bus.mem_w = 1'b0;  bus.mem_addr = 32'h0;  bus.mem_wdata = 32'h0;
        bus0.mem_r = 1'b0; bus0.mem_w = 1'b0; bus0.mem_addr = 32'h0; bus0.mem_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_led", {16'h0, led_out}, 32'h0);
        chk("reset_rdata", bus.mem_rdata, 32'h0);
        #1 reset = 1'b0;
        idle(2);

        txn(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678);
        txn(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        chk("ram_read", bus.mem_rdata, 32'h1234_5678);

        txn(1'b0, 1'b1, 32'hFFFF_FF00, 32'h0000_A5A5);
        chk("led_write", {16'h0, led_out}, 32'h0000_A5A5);
        txn(1'b1, 1'b0, 32'hFFFF_FF04, 32'h0);
        chk("sw_read", bus.mem_rdata, 32'h0000_00F0);

        txn(1'b1, 1'b0, 32'h0000_1000, 32'h0);
        chk("oor_rdata", bus.mem_rdata, 32'h0);
        chk("oor_err", {31'h0, err}, 32'h1);
        txn(1'b0, 1'b1, 32'hFFFF_FF0C, 32'h1);
        chk("stat_clear", {31'h0, err}, 32'h0);
        txn(1'b0, 1'b1, 32'hFFFF_FF0D, 32'h1);
        chk("set_wins", {31'h0, err}, 32'h1);
        txn(1'b0, 1'b1, 32'hFFFF_FF0C, 32'h1);
        chk("stat_clear2", {31'h0, err}, 32'h0);

        txn(1'b0, 1'b1, 32'hFFFF_FF08, 32'hFFFF_FFFE);
        idle(4);
        txn(1'b1, 1'b0, 32'hFFFF_FF08, 32'h0);
        chk("cnt_wrap", bus.mem_rdata, 32'h0000_0003);

        txn(1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D);
        txn(1'b1, 1'b0, 32'h0000_0012, 32'h0);
        chk("unaligned_rdata", bus.mem_rdata, 32'h1234_5678);
        chk("unaligned_err", {31'h0, err}, 32'h1);

        // Abort a write in its wait state.
        bus.mem_w = 1'b1; bus.mem_addr = 32'h0000_0020; bus.mem_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.mem_w = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'h0, bus.busy}, 32'h0);
        chk("abort_ready", {31'h0, bus.mem_ready}, 32'h0);
        chk("abort_led", {16'h0, led_out}, 32'h0);
        chk("abort_err", {31'h0, err}, 32'h0);
        chk("abort_rdata", bus.mem_rdata, 32'h0);
        @(negedge clk); #1 reset = 1'b0;
        idle(1);
        txn(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        chk("abort_old_data", bus.mem_rdata, 32'h0BAD_F00D);

        // Zero-wait instance: both strobes -> write, ready one cycle after accept.
        bus0.mem_r = 1'b1; bus0.mem_w = 1'b1; bus0.mem_addr = 32'h0000_0004; bus0.mem_wdata = 32'h1111_2222;
        @(posedge clk); #1;
        bus0.mem_r = 1'b0; bus0.mem_w = 1'b0;
        @(negedge clk);
        chk("w0_ready", {31'h0, bus0.mem_ready}, 32'h1);
        chk("w0_busy", {31'h0, bus0.busy}, 32'h1);
        @(negedge clk);
        chk("w0_ready_low", {31'h0, bus0.mem_ready}, 32'h0);
        chk("w0_busy_low", {31'h0, bus0.busy}, 32'h0);
        chk("w0_err", {31'h0, err0}, 32'h1);
        #1 bus0.mem_r = 1'b1; bus0.mem_addr = 32'h0000_0004;
        @(posedge clk); #1;
        bus0.mem_r = 1'b0;
        @(negedge clk);
        chk("w0_read_ready", {31'h0, bus0.mem_ready}, 32'h1);
        chk("w0_read_data", bus0.mem_rdata, 32'h1111_2222);

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU bus. It serves the CPU's instruction fetches and load/store accesses.
- Contents: a word-addressed RAM, a small memory-mapped I/O window (LEDs, switches, cycle counter, status) and a programmable wait-state sequencer.
- It drives mem_ready so the control FSM can stall until read data is valid or a write has committed.
- Sits between the CPU top level and the board I/O.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words. Must be a power of 2, at most 2^28.
- WAIT_CYCLES, 1: extra cycles between accept and response. Range 0-15.
- IO_BASE, 32'hFFFF_FF00: base of the 16-byte I/O window.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- mem_addr  in  32  byte address from the CPU
- mem_wdata  in  32  store data (CPU rt register)
- mem_r  in  1  read request strobe
- mem_w  in  1  write request strobe
- mem_rdata  out  32  read data, valid when mem_ready=1
- mem_ready  out  1  one-cycle completion pulse
- busy  out  1  high while a transaction is outstanding
- sw_in  in  16  board switches, asynchronous
- led_out  out  16  LED register
- err  out  1  sticky bus-error flag

Behaviour:
- Reset is asynchronous, clock is clk. Reset values: mem_rdata=0, mem_ready=0, busy=0, led_out=0, err=0, counter=0, sw sync regs=0, FSM=IDLE. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_r or mem_w is high at a clock edge, latch addr, wdata and kind, set busy=1.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
  - If both strobes are high, treat the request as a write and set err.
- WAIT: a 4-bit down-counter is loaded with WAIT_CYCLES-1 on accept. Stay in WAIT until it reaches 0, then go to RESP.
- RESP:
  - mem_ready=1 for exactly this cycle; busy stays 1.
  - Reads: mem_rdata is registered on the edge entering RESP and held until the next read's RESP.
  - Writes: commit on the edge leaving RESP.
  - Next state is IDLE with busy=0. Strobes seen during WAIT/RESP are ignored; the CPU must hold or re-assert them.
- Total latency from accept edge to mem_ready high: WAIT_CYCLES+1 cycles.
- Address decode uses the latched address:
  - addr[31:4]==IO_BASE[31:4]: I/O window, register = addr[3:2].
  - else if addr[31:2] < MEM_WORDS: RAM word addr[31:2].
  - else: out of range. Reads return 32'h0000_0000, writes are dropped, err is set.
- Unaligned access (addr[1:0]!=0): the access proceeds on the word addr[31:2] and err is set.
- I/O registers:
  - 0x0 LED: read returns {16'b0, led_out}; write loads led_out from wdata[15:0].
  - 0x4 SW: read returns {16'b0, sw_sync}; writes ignored. sw_in passes through a 2-flop synchronizer.
  - 0x8 CNT: free-running 32-bit cycle counter, wraps 0xFFFF_FFFF to 0. A write loads wdata and takes priority over the increment that cycle; the counter increments from the loaded value on the next cycle.
  - 0xC STAT: read returns {30'b0, busy, err}. Write with wdata[0]=1 clears err. If an error occurs in the same cycle as the clear, err stays set (set wins).
- Reset mid-transaction aborts immediately: no RAM or I/O write is committed, FSM returns to IDLE, mem_ready stays 0.
- err stays set until cleared through STAT or by reset.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - I/O register offsets (IO_LED=2'd0, IO_SW=2'd1, IO_CNT=2'd2, IO_STAT=2'd3).
  - Default IO_BASE constant.
- Sub-module: resp_ram, a single-port synchronous RAM (MEM_WORDS x 32; one read or write per cycle; registered read). It keeps the array inferable as block RAM.
- FSM, decode, I/O registers and counter stay in the top module.

Test Plan:
- WAIT_CYCLES=1: write 32'h1234_5678 to addr 0x10, then read 0x10 -> mem_ready exactly 2 cycles after each accept; read mem_rdata=32'h1234_5678; busy high from accept through RESP.
- Write 0x0000_A5A5 to 0xFFFF_FF00 -> led_out=16'hA5A5; read 0xFFFF_FF04 with sw_in=16'h00F0 held -> mem_rdata=32'h0000_00F0.
- Read 0x0000_1000 (word 1024 with MEM_WORDS=1024) -> mem_rdata=0, err=1; write 1 to 0xFFFF_FF0C -> err=0.
- Write 32'hFFFF_FFFE to CNT, then read CNT several cycles later -> value wrapped past 0 and equals the elapsed-cycle count minus 2.
- Assert reset during WAIT of a write of 32'hDEAD_BEEF to 0x20 -> mem_ready never pulses; a later read of 0x20 returns the old contents; all outputs at their reset values.
- WAIT_CYCLES=0 with mem_r and mem_w both high at 0x4 -> treated as a write, mem_ready 1 cycle after accept, err=1.
